// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage branch resolution.
// Computes the real next PC for branches/jumps, issues a registered one-cycle
// redirect/flush pulse, keeps resolution statistics, and (when the macro
// BRANCH_PREDICT_EN is defined) trains a 2-bit-counter branch history table
// whose prediction is served combinationally to fetch.
//
// Acceptance handshake: an EX instruction is consumed in a cycle exactly when
// ex_valid & ~ex_stall & ~redirect_valid. While a redirect pulse is visible the
// EX instruction is wrong-path and has no effect at all; ex_stall only holds
// the instruction and never stretches or cancels a registered pulse.
module branch_resolver #(
  parameter int BHT_ENTRIES = 16,
  parameter int XLEN        = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_cmp_res,
  input  logic            ex_pred_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  logic            accept;
  logic            is_cond;
  logic            taken;
  logic            redirect_d;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  // Decode class with JALR > JAL > branch precedence, resolve outcome and target.
  always_comb begin
    accept   = ex_valid & ~ex_stall & ~redirect_valid;
    is_cond  = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
    taken    = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_cmp_res);
    jalr_sum = ex_rs1 + ex_imm;
    target   = ex_pc + XLEN'(4);
    if (ex_is_jalr) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (taken) begin
      target = ex_pc + ex_imm;
    end
    redirect_d = 1'b0;
    if (ex_is_jalr || ex_is_jal) begin
      redirect_d = 1'b1;
    end else if (is_cond) begin
`ifdef BRANCH_PREDICT_EN
      redirect_d = (taken != ex_pred_taken);
`else
      redirect_d = taken;
`endif
    end
  end

  // Redirect pulse register; the target holds its last value between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept & redirect_d;
      if (accept && redirect_d) begin
        redirect_pc <= target;
      end
    end
  end

  // Statistics: resolved conditional branches and those that redirected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (accept && is_cond) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (redirect_d) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

`ifdef BRANCH_PREDICT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_pc_bits;

  // Word-aligned PC bits select the counter; lookup reads pre-update contents.
  always_comb begin
    if_idx         = if_pc[IDX_W+1:2];
    ex_idx         = ex_pc[IDX_W+1:2];
    if_pred_taken  = bht[if_idx][1];
    unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};
  end

  // Saturating 2-bit counter training on accepted conditional branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (accept && is_cond) begin
      if (taken && bht[ex_idx] != 2'b11) begin
        bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else if (!taken && bht[ex_idx] != 2'b00) begin
        bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end
`else
  localparam int UNUSED_ENTRIES = BHT_ENTRIES;

  logic unused_pred_inputs;

  // Without a predictor fetch always assumes not-taken.
  always_comb begin
    if_pred_taken      = 1'b0;
    unused_pred_inputs = ^{if_pc, ex_pred_taken};
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed scenarios plus randomized traffic for
// branch_resolver, checked against a behavioural model of the resolution
// rules (build with BRANCH_PREDICT_EN defined to include the predictor).
module tb_branch_resolver;

  localparam int ENTRIES = 16;
  localparam int XL      = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XL-1:0] if_pc = '0;
  logic          if_pred_taken;
  logic          ex_valid = 1'b0;
  logic          ex_stall = 1'b0;
  logic          ex_is_branch = 1'b0;
  logic          ex_is_jal = 1'b0;
  logic          ex_is_jalr = 1'b0;
  logic [XL-1:0] ex_pc = '0;
  logic [XL-1:0] ex_imm = '0;
  logic [XL-1:0] ex_rs1 = '0;
  logic          ex_cmp_res = 1'b0;
  logic          ex_pred_taken = 1'b0;
  logic          redirect_valid;
  logic [XL-1:0] redirect_pc;
  logic [31:0]   branch_cnt;
  logic [31:0]   mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [XL-1:0] exp_q[$];
  bit            m_rv;
  logic [XL-1:0] m_rpc;
  int unsigned   m_bcnt, m_mcnt;
  int            m_bht [ENTRIES];

  branch_resolver #(.BHT_ENTRIES(ENTRIES), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_cmp_res(ex_cmp_res),
    .ex_pred_taken(ex_pred_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_rv = 0; m_rpc = '0; m_bcnt = 0; m_mcnt = 0;
    for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
  endtask

  function automatic bit model_pred(logic [XL-1:0] pc);
`ifdef BRANCH_PREDICT_EN
    return m_bht[int'((pc / 4) % ENTRIES)] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  // Applies the resolution rules to the inputs present just before an edge.
  task automatic model_edge();
    int kind; // 0 none, 1 conditional branch, 2 JAL, 3 JALR
    bit tk, redir, acc;
    logic [XL-1:0] tgt;
    int idx;
    acc = ex_valid && !ex_stall && !m_rv;
    kind = ex_is_jalr ? 3 : ex_is_jal ? 2 : ex_is_branch ? 1 : 0;
    tk = (kind >= 2) || (kind == 1 && ex_cmp_res);
    if (kind == 3) tgt = ((ex_rs1 + ex_imm) / 2) * 2;
    else if (tk)   tgt = ex_pc + ex_imm;
    else           tgt = ex_pc + 4;
`ifdef BRANCH_PREDICT_EN
    redir = (kind >= 2) || (kind == 1 && tk != ex_pred_taken);
`else
    redir = (kind >= 2) || (kind == 1 && tk);
`endif
    if (acc && kind == 1) begin
      m_bcnt++;
      if (redir) m_mcnt++;
      idx = int'((ex_pc / 4) % ENTRIES);
      m_bht[idx] = tk ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                      : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
    end
    m_rv = acc && redir;
    if (m_rv) begin
      m_rpc = tgt;
      exp_q.push_back(tgt);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, bit st, bit br, bit jal, bit jalr, logic [XL-1:0] pc,
                       logic [XL-1:0] imm, logic [XL-1:0] rs1, bit cmp, bit pred);
    ex_valid = v; ex_stall = st; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_cmp_res = cmp; ex_pred_taken = pred;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, '0, '0, '0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b exp 0", redirect_valid); end
    n_tests++; if (redirect_pc !== '0) begin n_fail++; $display("FAIL reset_rpc got %h exp 0", redirect_pc); end
    n_tests++; if (branch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_bcnt got %0d exp 0", branch_cnt); end
    n_tests++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_mcnt got %0d exp 0", mispred_cnt); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_beq_mispredict();
    drive(1, 0, 1, 0, 0, 64'h100, 64'h20, '0, 1, 0);
    tick();
    drive_idle();
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_rv got %b exp 1", redirect_valid); end
    n_tests++; if (redirect_pc !== 64'h120) begin n_fail++; $display("FAIL beq_rpc got %h exp 120", redirect_pc); end
    n_tests++; if (branch_cnt !== 32'd1) begin n_fail++; $display("FAIL beq_bcnt got %0d exp 1", branch_cnt); end
    n_tests++; if (mispred_cnt !== 32'd1) begin n_fail++; $display("FAIL beq_mcnt got %0d exp 1", mispred_cnt); end
`ifdef BRANCH_PREDICT_EN
    if_pc = 64'h0; #1;
    n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL beq_bht0 got %b exp 1", if_pred_taken); end
`endif
    tick();
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_end got %b exp 0", redirect_valid); end
    n_tests++; if (redirect_pc !== 64'h120) begin n_fail++; $display("FAIL rpc_hold got %h exp 120", redirect_pc); end
  endtask

  task automatic test_bne_not_taken();
    drive(1, 0, 1, 0, 0, 64'h200, 64'h80, '0, 0, 0);
    tick();
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bne_rv got %b exp 0", redirect_valid); end
    n_tests++; if (branch_cnt !== 32'd2) begin n_fail++; $display("FAIL bne_bcnt1 got %0d exp 2", branch_cnt); end
    tick();
    tick();
    drive_idle();
    n_tests++; if (branch_cnt !== 32'd4) begin n_fail++; $display("FAIL bne_bcnt3 got %0d exp 4", branch_cnt); end
    n_tests++; if (mispred_cnt !== 32'd1) begin n_fail++; $display("FAIL bne_mcnt got %0d exp 1", mispred_cnt); end
`ifdef BRANCH_PREDICT_EN
    // Saturated at 00: two taken (correctly predicted) steps must land on 10.
    drive(1, 0, 1, 0, 0, 64'h200, 64'h80, '0, 1, 1);
    tick();
    tick();
    drive_idle();
    if_pc = 64'h200; #1;
    n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL bht_sat_low got %b exp 1", if_pred_taken); end
`endif
    tick();
  endtask

  task automatic test_jalr_shadow();
    int unsigned b0, m0;
    drive(1, 0, 0, 0, 1, 64'h500, 64'h4, 64'h1003, 0, 0);
    tick();
    b0 = branch_cnt; m0 = mispred_cnt;
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL jalr_rv got %b exp 1", redirect_valid); end
    n_tests++; if (redirect_pc !== 64'h1006) begin n_fail++; $display("FAIL jalr_rpc got %h exp 1006", redirect_pc); end
    drive(1, 0, 1, 0, 0, 64'h600, 64'h8, '0, 1, 0);
    tick();
    drive_idle();
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL shadow_rv got %b exp 0", redirect_valid); end
    n_tests++; if (redirect_pc !== 64'h1006) begin n_fail++; $display("FAIL shadow_rpc got %h exp 1006", redirect_pc); end
    n_tests++; if (branch_cnt !== b0 || mispred_cnt !== m0) begin
      n_fail++; $display("FAIL shadow_cnt got %0d/%0d exp %0d/%0d", branch_cnt, mispred_cnt, b0, m0);
    end
    tick();
  endtask

  task automatic test_stall();
    int unsigned b0;
    b0 = branch_cnt;
    drive(1, 1, 1, 0, 0, 64'h300, 64'h40, '0, 1, 0);
    tick();
    tick();
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL stall_rv got %b exp 0", redirect_valid); end
    n_tests++; if (branch_cnt !== b0) begin n_fail++; $display("FAIL stall_bcnt got %0d exp %0d", branch_cnt, b0); end
    ex_stall = 1'b0;
    tick();
    drive_idle();
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL unstall_rv got %b exp 1", redirect_valid); end
    n_tests++; if (redirect_pc !== 64'h340) begin n_fail++; $display("FAIL unstall_rpc got %h exp 340", redirect_pc); end
    n_tests++; if (branch_cnt !== b0 + 1) begin n_fail++; $display("FAIL unstall_bcnt got %0d exp %0d", branch_cnt, b0 + 1); end
    tick();
  endtask

  task automatic test_train_saturate();
    drive(1, 0, 1, 0, 0, 64'h40, 64'h10, '0, 1, 1);
    repeat (4) tick();
    drive_idle();
    tick();
    if_pc = 64'h40; #1;
`ifdef BRANCH_PREDICT_EN
    n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_pred got %b exp 1", if_pred_taken); end
    // Same-cycle lookup while the same counter is being decremented.
    drive(1, 0, 1, 0, 0, 64'h40, 64'h10, '0, 0, 1);
    #1;
    n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL bypass_pred got %b exp 1", if_pred_taken); end
    tick();
    drive_idle();
    n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL after_dec_pred got %b exp 1", if_pred_taken); end
`else
    n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL nopred got %b exp 0", if_pred_taken); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 1, 0, 64'h700, 64'h100, '0, 0, 0);
    tick();
    drive_idle();
    n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h800) begin
      n_fail++; $display("FAIL jal_pulse got %b/%h exp 1/800", redirect_valid, redirect_pc);
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rv got %b exp 0", redirect_valid); end
    n_tests++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      n_fail++; $display("FAIL midrst_cnt got %0d/%0d exp 0/0", branch_cnt, mispred_cnt);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if_pc = XL'(i * 4); #1;
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_pred idx %0d got %b exp 0", i, if_pred_taken); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_rv got %b exp 0", redirect_valid); end
  endtask

  task automatic test_random();
    int r;
    logic [XL-1:0] e;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            r < 6 || r == 9, r == 6 || r == 9, r == 7,
            XL'($urandom_range(0, 255)) * 4, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 1), $urandom_range(0, 1));
      if_pc = XL'($urandom_range(0, 255)) * 4;
      #1;
      n_tests++; if (if_pred_taken !== model_pred(if_pc)) begin
        n_fail++; $display("FAIL rnd_pred cyc %0d got %b exp %b", c, if_pred_taken, model_pred(if_pc));
      end
      tick();
      n_tests++; if (redirect_valid !== m_rv) begin
        n_fail++; $display("FAIL rnd_rv cyc %0d got %b exp %b", c, redirect_valid, m_rv);
      end
      if (redirect_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_rpc cyc %0d got %h exp none", c, redirect_pc);
        end else begin
          e = exp_q.pop_front();
          if (redirect_pc !== e) begin n_fail++; $display("FAIL rnd_rpc cyc %0d got %h exp %h", c, redirect_pc, e); end
        end
      end
      n_tests++; if (redirect_pc !== m_rpc) begin
        n_fail++; $display("FAIL rnd_rpc_hold cyc %0d got %h exp %h", c, redirect_pc, m_rpc);
      end
      n_tests++; if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
        n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", c, branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
      end
    end
    drive_idle();
  endtask

  // Sequencer and final report
  initial begin
    model_reset();
    test_reset();
    test_beq_mispredict();
    test_bne_not_taken();
    test_jalr_shadow();
    test_stall();
    test_train_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
